// File: rtl/ultrasonic_scan_scheduler_if.sv
// Engine-side bundle of the ultrasonic scan scheduler: start/select towards the
// shared ranging engine, done/distance back from it.
interface ultrasonic_scan_scheduler_if #(
    parameter int CH_W   = 2,
    parameter int DIST_W = 16
);
    logic              meas_start;
    logic [CH_W-1:0]   meas_sel;
    logic              meas_done;
    logic [DIST_W-1:0] meas_dist;

    modport master (
        output meas_start,
        output meas_sel,
        input  meas_done,
        input  meas_dist
    );

    modport slave (
        input  meas_start,
        input  meas_sel,
        output meas_done,
        output meas_dist
    );
endinterface

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler sharing one ultrasonic ranging engine among NUM_CH sensors.
// Define ULTRA_SCAN_FILTER_EN to average each new sample with the stored valid one.
//
// state  | meaning
// IDLE   | not scanning, waiting for enable with a non-empty mask
// SELECT | pick next enabled channel after last_ch and route it to the engine
// START  | one-cycle start pulse, counter cleared
// WAIT   | waiting for meas_done or the timeout terminal count
// GUARD  | quiet interval before the next ping
module ultrasonic_scan_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int DIST_W         = 16,
    parameter int TIMEOUT_CYCLES = 3000000,
    parameter int GUARD_CYCLES   = 6000000,
    parameter int CNT_W          = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    ultrasonic_scan_scheduler_if.master engine,
    output logic [NUM_CH*DIST_W-1:0] dist_flat,
    output logic [NUM_CH-1:0]        valid,
    output logic [NUM_CH-1:0]        timeout_err,
    output logic                     frame_done,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        GUARD
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CH_W-1:0]     sel;
    logic [CH_W-1:0]     last_ch;
    logic [CH_W-1:0]     cand;
    logic [CH_W-1:0]     pick;
    logic                pick_ok;
    logic [CH_W-1:0]     top_ch;
    logic                timeout_hit;
    logic                guard_hit;
    logic                wait_exit;
    logic [DIST_W-1:0]   store_val;
    logic [DIST_W-1:0]   dist_q [NUM_CH];

    // Round-robin search starts one past the last served channel.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(last_ch) + k) % NUM_CH);
            if (!pick_ok && ch_mask[cand]) begin
                pick_ok = 1'b1;
                pick    = cand;
            end
        end
    end

    always_comb begin
        top_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_mask[i]) begin
                top_ch = CH_W'(i);
            end
        end
    end

    assign timeout_hit = (state == WAIT) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign guard_hit   = (state == GUARD) && (cnt == CNT_W'(GUARD_CYCLES - 1));
    assign wait_exit   = (state == WAIT) && (engine.meas_done || timeout_hit);

`ifdef ULTRA_SCAN_FILTER_EN
    logic [DIST_W:0] dist_sum;
    assign dist_sum  = {1'b0, dist_q[sel]} + {1'b0, engine.meas_dist};
    assign store_val = valid[sel] ? dist_sum[DIST_W:1] : engine.meas_dist;
`else
    assign store_val = engine.meas_dist;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (ch_mask != '0)) begin
                    state_nxt = SELECT;
                end
            end
            SELECT: state_nxt = pick_ok ? START : IDLE;
            START:  state_nxt = WAIT;
            WAIT: begin
                if (wait_exit) begin
                    state_nxt  = GUARD;
                    frame_done = (ch_mask != '0) && (sel == top_ch);
                end
            end
            GUARD: begin
                if (guard_hit) begin
                    state_nxt = (enable && (ch_mask != '0)) ? SELECT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy              = (state != IDLE);
    assign engine.meas_start = (state == START);
    assign engine.meas_sel   = sel;

    // Single counter serves both the timeout and the guard; it holds at terminal count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= '0;
            sel         <= '0;
            last_ch     <= CH_W'(NUM_CH - 1);
            valid       <= '0;
            timeout_err <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dist_q[i] <= '0;
            end
        end else begin
            case (state)
                SELECT: begin
                    if (pick_ok) begin
                        sel     <= pick;
                        last_ch <= pick;
                    end
                end
                START: cnt <= '0;
                WAIT: begin
                    if (wait_exit) begin
                        cnt <= '0;
                    end else if (!timeout_hit) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GUARD: begin
                    if (!guard_hit) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (wait_exit) begin
                if (engine.meas_done) begin
                    dist_q[sel]      <= store_val;
                    valid[sel]       <= 1'b1;
                    timeout_err[sel] <= 1'b0;
                end else begin
                    dist_q[sel]      <= '1;
                    valid[sel]       <= 1'b0;
                    timeout_err[sel] <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_flat
        assign dist_flat[i*DIST_W +: DIST_W] = dist_q[i];
    end

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Bench for ultrasonic_scan_scheduler: directed scenarios plus a randomized scan,
// all checked against a channel-level model of distances, flags and ping timing.
module tb_ultrasonic_scan_scheduler;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int DIST_W = 16;
    localparam int TO     = 50;
    localparam int GD     = 10;
    localparam int CNT_W  = 23;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     enable = 1'b0;
    logic [NUM_CH-1:0]        ch_mask = '0;
    logic [NUM_CH*DIST_W-1:0] dist_flat;
    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH-1:0]        timeout_err;
    logic                     frame_done;
    logic                     busy;

    ultrasonic_scan_scheduler_if #(.CH_W(CH_W), .DIST_W(DIST_W)) eng ();

    ultrasonic_scan_scheduler #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DIST_W(DIST_W),
        .TIMEOUT_CYCLES(TO), .GUARD_CYCLES(GD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .engine(eng.master), .dist_flat(dist_flat), .valid(valid),
        .timeout_err(timeout_err), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DIST_W-1:0] m_dist [NUM_CH];
    logic [NUM_CH-1:0] m_valid;
    logic [NUM_CH-1:0] m_to;
    int                m_last;
    int                prev_start;
    int                prev_gap;
    bit                prev_ok;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int next_ch();
        for (int k = 1; k <= NUM_CH; k++) begin
            if (ch_mask[(m_last + k) % NUM_CH]) return (m_last + k) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic int top_ch();
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_CH*DIST_W-1:0] m_flat();
        logic [NUM_CH*DIST_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_CH; i++) f[i*DIST_W +: DIST_W] = m_dist[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_dist[i] = '0;
        m_valid = '0;
        m_to    = '0;
        m_last  = NUM_CH - 1;
        prev_ok = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_dist"}, 64'(dist_flat), 64'(m_flat()));
        chk({tag, "_valid"}, 64'(valid), 64'(m_valid));
        chk({tag, "_tmo"}, 64'(timeout_err), 64'(m_to));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        eng.meas_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Called in an IDLE cycle; start must appear two cycles later.
    task automatic kick();
        enable = 1'b1;
        @(negedge clk);
        chk("kick_sel_busy", 64'(busy), 64'(1));
        chk("kick_sel_nostart", 64'(eng.meas_start), 64'(0));
        @(negedge clk);
        chk("kick_start", 64'(eng.meas_start), 64'(1));
        prev_ok = 1'b0;
    endtask

    // One ping: delay 0 = engine stays silent. Returns in the cycle after GUARD.
    task automatic do_meas(input int delay, input logic [DIST_W-1:0] d,
                           input bit drop_en, input bit guard_poke);
        int n;
        int ch;
        int hit;
        n = 0;
        while (eng.meas_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 64'(eng.meas_start), 64'(1));
        if (eng.meas_start !== 1'b1) return;
        ch = next_ch();
        m_last = ch;
        chk("sel", 64'(eng.meas_sel), 64'(ch));
        if (prev_ok) chk("ping_gap", 64'(cyc - prev_start), 64'(prev_gap));
        prev_start = cyc;
        hit = 0;
        for (int c = 1; c <= TO && hit == 0; c++) begin
            @(negedge clk);
            if (drop_en && c == 1) enable = 1'b0;
            eng.meas_done = (c == delay);
            eng.meas_dist = (c == delay) ? d : DIST_W'($urandom);
            #1;
            if (c == 1) chk("wait_nostart", 64'(eng.meas_start), 64'(0));
            if (c == delay || c == TO) begin
                hit = c;
                chk("frame_done", 64'(frame_done), 64'(ch == top_ch()));
                chk("sel_hold", 64'(eng.meas_sel), 64'(ch));
            end else if (c % 8 == 0) begin
                chk("no_frame_done", 64'(frame_done), 64'(0));
            end
        end
        if (hit == delay) begin
`ifdef ULTRA_SCAN_FILTER_EN
            if (m_valid[ch]) m_dist[ch] = DIST_W'((int'(m_dist[ch]) + int'(d)) / 2); else
`endif
            m_dist[ch] = d;
            m_valid[ch] = 1'b1;
            m_to[ch]    = 1'b0;
        end else begin
            m_dist[ch]  = '1;
            m_valid[ch] = 1'b0;
            m_to[ch]    = 1'b1;
        end
        @(negedge clk);
        for (int g = 1; g <= GD; g++) begin
            if (g > 1) @(negedge clk);
            eng.meas_done = guard_poke && (g == 4);
            eng.meas_dist = DIST_W'($urandom);
        end
        chk("guard_busy", 64'(busy), 64'(1));
        @(negedge clk);
        eng.meas_done = 1'b0;
        chk("post_guard_busy", 64'(busy), 64'(enable && ch_mask != '0));
        chk("post_guard_nostart", 64'(eng.meas_start), 64'(0));
        check_regs("meas");
        prev_gap = hit + GD + 2;
        prev_ok  = enable;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int dl[9] = '{20, 20, 0, 20, 20, 20, 15, 50, 30};

    initial begin
        logic [DIST_W-1:0] exp_f;
        eng.meas_done = 1'b0;
        eng.meas_dist = '0;
        do_reset();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_start", 64'(eng.meas_start), 64'(0));
        chk("rst_sel", 64'(eng.meas_sel), 64'(0));
        chk("rst_frame", 64'(frame_done), 64'(0));
        check_regs("rst");

        // full mask, ch answers 100+ch after 20 cycles
        ch_mask = 4'b1111;
        kick();
        for (int i = 0; i < 5; i++) do_meas(20, DIST_W'(100 + next_ch()), 1'b0, 1'b0);

        // sparse mask after a fresh reset
        do_reset();
        ch_mask = 4'b1010;
        kick();
        for (int i = 0; i < 4; i++) do_meas(20, DIST_W'(300 + i), 1'b0, 1'b0);

        // timeout on ch2, recovery, coincident done/timeout, guard poke, enable drop
        ch_mask = 4'b1111;
        for (int i = 0; i < 9; i++) do_meas(dl[i], DIST_W'(200 + i * 7), i == 8, i == 7);
        chk("idle_after_drop", 64'(busy), 64'(0));

        // reset in the middle of WAIT, then a late done
        kick();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        model_reset();
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_sel", 64'(eng.meas_sel), 64'(0));
        chk("midrst_start", 64'(eng.meas_start), 64'(0));
        check_regs("midrst");
        reset = 1'b1;
        eng.meas_done = 1'b1;
        eng.meas_dist = 16'h1234;
        @(negedge clk);
        eng.meas_done = 1'b0;
        @(negedge clk);
        chk("late_done_busy", 64'(busy), 64'(0));
        check_regs("late_done");

        // averaging (or raw) on ch0: 100 then 51
        do_reset();
        ch_mask = 4'b0001;
        kick();
        do_meas(20, 16'd100, 1'b0, 1'b0);
        do_meas(20, 16'd51, 1'b1, 1'b0);
`ifdef ULTRA_SCAN_FILTER_EN
        exp_f = 16'd75;
`else
        exp_f = 16'd51;
`endif
        chk("ch0_second_sample", 64'(dist_flat[DIST_W-1:0]), 64'(exp_f));

        // randomized scan
        do_reset();
        ch_mask = NUM_CH'($urandom_range(1, 15));
        kick();
        for (int i = 0; i < 40; i++) begin
            int  dly;
            bit  drop;
            dly  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TO));
            drop = (i == 39) || ($urandom_range(0, 9) == 0);
            do_meas(dly, DIST_W'($urandom), drop, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) ch_mask = NUM_CH'($urandom_range(1, 15));
            if (drop && i != 39) kick();
        end
        chk("final_idle", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
